reg_bank: RTL

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 18 +
 rtl/reg_bank_if.sv | 35 +++
 rtl/reg_bank_clr_seq.sv | 62 ++++++
 rtl/reg_bank.sv | 90 +++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
`default_nettype none
//============================================================================
// Module : reg_bank_pkg
// Brief  : Shared sequencer state type and default geometry for reg_bank.
// Rev    : 1.0
//============================================================================
package reg_bank_pkg;

    localparam int unsigned c_dw_default = 8;
    localparam int unsigned c_aw_default = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/reg_bank_if.sv
`default_nettype none
//============================================================================
// Module : reg_bank_if
// Brief  : Read/write/clear bus of reg_bank; master drives, slave is the bank.
// Rev    : 1.0
//============================================================================
interface reg_bank_if
    import reg_bank_pkg::*;
#(
    parameter int unsigned DW = c_dw_default,
    parameter int unsigned AW = c_aw_default
) ();

    logic [AW-1:0] rd_a_addr;
    logic [AW-1:0] rd_b_addr;
    logic [DW-1:0] rd_a_data;
    logic [DW-1:0] rd_b_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          clr_req;
    logic          busy;

    modport master (
        output rd_a_addr, rd_b_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_a_data, rd_b_data, busy
    );

    modport slave (
        input  rd_a_addr, rd_b_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_a_data, rd_b_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/reg_bank_clr_seq.sv
`default_nettype none
//============================================================================
// Module : reg_bank_clr_seq
// Brief  : Clear sequencer; sweeps clr_ptr over every entry while busy.
// Rev    : 1.0
//============================================================================
module reg_bank_clr_seq
    import reg_bank_pkg::*;
#(
    parameter int unsigned AW = c_aw_default
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          clr_req,
    output logic               busy,
    output logic [AW-1:0]      clr_ptr
);

    localparam logic [AW-1:0] c_last_ptr = '1;

    seq_state_e    state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                // The natural wrap of the pointer lands on the exit edge.
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == c_last_ptr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                clr_ptr_d = '0;
            end
        endcase
    end

    assign busy    = (state_q == CLEAR);
    assign clr_ptr = clr_ptr_q;

endmodule
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
//============================================================================
// Module : reg_bank
// Brief  : 2-read/1-write register bank with sequenced clear.
//          Optional REG_BANK_BYPASS_EN forwards same-cycle write data to reads.
// Rev    : 1.0
//============================================================================
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned DW      = c_dw_default,
    parameter int unsigned AW      = c_aw_default,
    parameter int unsigned ZERO_R0 = 1
) (
    input wire logic clk,
    input wire logic rst,
    reg_bank_if.slave bus
);

    localparam int unsigned c_depth = 2 ** AW;
    localparam bit          c_zero_r0 = (ZERO_R0 != 0);

    logic [DW-1:0] mem_q [c_depth];

    logic          busy;
    logic [AW-1:0] clr_ptr;
    logic          user_wr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;

    reg_bank_clr_seq #(
        .AW (AW)
    ) u_clr_seq (
        .clk     (clk),
        .rst     (rst),
        .clr_req (bus.clr_req),
        .busy    (busy),
        .clr_ptr (clr_ptr)
    );

    always_comb begin
        user_wr   = bus.wr_en && !busy && !bus.clr_req && !rst &&
                    !(c_zero_r0 && (bus.wr_addr == '0));
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr;
            mem_wdata = '0;
        end else if (user_wr) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_a = mem_q[bus.rd_a_addr];
        rd_b = mem_q[bus.rd_b_addr];
`ifdef REG_BANK_BYPASS_EN
        if (bus.wr_en && (bus.wr_addr == bus.rd_a_addr)) begin
            rd_a = bus.wr_data;
        end
        if (bus.wr_en && (bus.wr_addr == bus.rd_b_addr)) begin
            rd_b = bus.wr_data;
        end
`endif
        // Zeroing is applied last so it overrides any forwarded data.
        if (busy || (c_zero_r0 && (bus.rd_a_addr == '0))) begin
            rd_a = '0;
        end
        if (busy || (c_zero_r0 && (bus.rd_b_addr == '0))) begin
            rd_b = '0;
        end
    end

    assign bus.rd_a_data = rd_a;
    assign bus.rd_b_data = rd_b;
    assign bus.busy      = busy;

endmodule
`default_nettype wire
